// File: rtl/matinv2_seq.sv
// Sequential 2x2 fixed-point matrix inverse: determinant, reciprocal by restoring
// division (one quotient bit per cycle), then adjugate scaling with saturation.
module matinv2_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DATA_WIDTH-1:0] a,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DATA_WIDTH-1:0] prod,
  output logic [1:0]              error_line
);

  localparam int W  = DATA_WIDTH;
  localparam int F  = FRAC_BITS;
  localparam int DW = 2*W + 1;
  localparam int QW = 2*F + 1;
  localparam int PW = 2*W + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);
  localparam longint MAXR_L = (longint'(1) << (W-1)) - 1;
  localparam logic signed [PW-1:0] MAXV = PW'(MAXR_L);
  localparam logic signed [PW-1:0] MINV = -MAXV - 1;

  typedef enum logic [2:0] {IDLE, DET, DIV, SCALE, DONE} state_t;

  state_t state, state_nx;
  logic   armed;

  logic signed [W-1:0]  a00, a01, a10, a11;
  logic signed [DW-1:0] det_q;
  logic [DW-1:0]        rem;
  logic [QW-1:0]        quo;
  logic [CW-1:0]        cnt;

  logic signed [DW-1:0] e00, e01, e10, e11, det_full, det_shift;
  logic [DW-1:0]        dabs, rem_nx;
  logic [DW:0]          trial;
  logic                 ge;
  logic [PW-1:0]        quo_ext;
  logic                 r_clamp;
  logic [W-1:0]         r_mag;
  logic signed [W:0]    r_s, x00, x01, x10, x11;
  logic signed [PW-1:0] f00, f01, f10, f11;
  logic [W:0]           c00, c01, c10, c11;
  logic [4*W-1:0]       prod_nx;
  logic                 sat_any;

  // Top bit of the result flags a clamp; the low W bits are the clamped value.
  function automatic logic [W:0] clip(input logic signed [PW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[W-1:0]};
    else if (v < MINV) return {1'b1, MINV[W-1:0]};
    else               return {1'b0, v[W-1:0]};
  endfunction

  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = DET;
      DET:     state_nx = DIV;
      DIV:     if (det_q == '0) state_nx = DONE;
               else if (cnt == LAST) state_nx = SCALE;
      SCALE:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Determinant and one restoring-division step; the dividend 2^(2F) has only its
  // top bit set, so the bit shifted in is 1 on the first step and 0 afterwards.
  always_comb begin
    e00 = a00;
    e01 = a01;
    e10 = a10;
    e11 = a11;
    det_full  = e00*e11 - e01*e10;
    det_shift = det_full >>> F;
    dabs   = det_q[DW-1] ? DW'(-det_q) : DW'(det_q);
    trial  = {rem, (cnt == '0)};
    ge     = (trial >= {1'b0, dabs});
    rem_nx = ge ? DW'(trial - {1'b0, dabs}) : DW'(trial);
  end

  always_comb begin
    quo_ext = PW'(quo);
    r_clamp = (quo_ext > PW'(MAXR_L));
    r_mag   = r_clamp ? MAXV[W-1:0] : quo_ext[W-1:0];
    r_s     = det_q[DW-1] ? -$signed({1'b0, r_mag}) : $signed({1'b0, r_mag});
    x00 = $signed({a00[W-1], a00});
    x01 = -$signed({a01[W-1], a01});
    x10 = -$signed({a10[W-1], a10});
    x11 = $signed({a11[W-1], a11});
    f00 = (r_s * x11) >>> F;
    f01 = (r_s * x01) >>> F;
    f10 = (r_s * x10) >>> F;
    f11 = (r_s * x00) >>> F;
    c00 = clip(f00);
    c01 = clip(f01);
    c10 = clip(f10);
    c11 = clip(f11);
    prod_nx = {c11[W-1:0], c10[W-1:0], c01[W-1:0], c00[W-1:0]};
    sat_any = r_clamp | c00[W] | c01[W] | c10[W] | c11[W];
  end

  // armed keeps in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      a00        <= '0;
      a01        <= '0;
      a10        <= '0;
      a11        <= '0;
      det_q      <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      prod       <= '0;
      error_line <= 2'b00;
    end else begin
      armed <= 1'b1;
      state <= state_nx;
      case (state)
        IDLE: if (in_valid && in_ready) {a11, a10, a01, a00} <= a;
        DET: begin
          det_q <= det_shift;
          rem   <= '0;
          quo   <= '0;
          cnt   <= '0;
        end
        DIV: begin
          if (det_q == '0) begin
            prod       <= '0;
            error_line <= 2'b01;
          end else begin
            rem <= rem_nx;
            quo <= {quo[QW-2:0], ge};
            cnt <= cnt + CW'(1);
          end
        end
        SCALE: begin
          prod       <= prod_nx;
          error_line <= sat_any ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matinv2_seq.sv
// Scoreboard bench for matinv2_seq: an integer reference model predicts each result
// and its latency, which are popped and compared when out_valid appears.
module tb_matinv2_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod;
  logic [1:0]  error_line;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] prod;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  matinv2_seq #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .error_line(error_line)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pk(input int e00, input int e01, input int e10, input int e11);
    return {16'(e11), 16'(e10), 16'(e01), 16'(e00)};
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input logic [63:0] m);
    exp_t e;
    longint m00, m01, m10, m11, det, dq, mag, r, p00, p01, p10, p11;
    bit sat;
    m00 = $signed(m[15:0]);
    m01 = $signed(m[31:16]);
    m10 = $signed(m[47:32]);
    m11 = $signed(m[63:48]);
    det = m00*m11 - m01*m10;
    dq  = det >>> 8;
    if (dq == 0) begin
      e.prod = '0;
      e.err  = 2'b01;
      e.lat  = 2;
      return e;
    end
    mag = (dq < 0) ? -dq : dq;
    r   = 65536 / mag;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end
    if (dq < 0) r = -r;
    p00 = (r * m11) >>> 8;
    p01 = (r * -m01) >>> 8;
    p10 = (r * -m10) >>> 8;
    p11 = (r * m00) >>> 8;
    if (clamp16(p00) != p00 || clamp16(p01) != p01 || clamp16(p10) != p10 || clamp16(p11) != p11)
      sat = 1'b1;
    e.prod = pk(int'(clamp16(p00)), int'(clamp16(p01)), int'(clamp16(p10)), int'(clamp16(p11)));
    e.err  = sat ? 2'b10 : 2'b00;
    e.lat  = 19;
    return e;
  endfunction

  task automatic applyStimulus(input logic [63:0] m);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    a = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(m));
  endtask

  task automatic collectResult(input bit hold, input bit pulse);
    exp_t e;
    int cyc = 0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    out_ready = !hold;
    while (!out_valid && cyc < 60) begin
      if (pulse && cyc == 4) begin
        in_valid = 1'b1;
        a = pk(1000, -7, 33, 5);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 64'(cyc), 64'(e.lat));
    checkOutput("prod", prod, e.prod);
    checkOutput("error_line", {62'd0, error_line}, {62'd0, e.err});
    checkOutput("in_ready_in_done", {63'd0, in_ready}, 64'd0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("hold_out_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("hold_prod", prod, e.prod);
        checkOutput("hold_error_line", {62'd0, error_line}, {62'd0, e.err});
        checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput("out_valid_after_handshake", {63'd0, out_valid}, 64'd0);
    checkOutput("in_ready_after_handshake", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    checkOutput({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, "_prod"}, prod, 64'd0);
    checkOutput({tag, "_error_line"}, {62'd0, error_line}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    #12;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_before_first_edge", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("in_ready_first_edge", {63'd0, in_ready}, 64'd1);

    applyStimulus(pk(256, 0, 0, 256));
    collectResult(1'b0, 1'b0);
    applyStimulus(pk(512, 256, 256, 256));
    collectResult(1'b0, 1'b0);
    applyStimulus(pk(256, 512, 128, 256));
    collectResult(1'b0, 1'b0);
    applyStimulus(pk(16, 0, 0, 16));
    collectResult(1'b0, 1'b0);
    applyStimulus(pk(0, 256, 256, 0));
    collectResult(1'b0, 1'b0);

    // Result held back by out_ready while extra in_valid pulses arrive mid-divide.
    applyStimulus(pk(512, 256, 256, 256));
    collectResult(1'b1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      int r00, r01, r10, r11;
      r00 = int'($urandom_range(0, 1023)) - 512;
      r01 = int'($urandom_range(0, 1023)) - 512;
      r10 = int'($urandom_range(0, 1023)) - 512;
      r11 = int'($urandom_range(0, 1023)) - 512;
      applyStimulus(pk(r00, r01, r10, r11));
      collectResult(1'b0, 1'b0);
    end

    // Reset in the middle of a divide, then a fresh identity matrix.
    applyStimulus(pk(256, 0, 0, 256));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_div_reset");
    sb.delete();
    #5;
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_release", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("in_ready_after_reset_edge", {63'd0, in_ready}, 64'd1);
    applyStimulus(pk(256, 0, 0, 256));
    collectResult(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
